// File: rtl/tone_gen.sv
// tone_gen: square-wave note player with programmable half-period and duration,
// followed by a fixed silent gap and a one-cycle done pulse.
module tone_gen #(
  parameter int DIV_W     = 25,
  parameter int DUR_W     = 16,
  parameter int TICK_DIV  = 50_000,
  parameter int GAP_TICKS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] half_period,
  input  logic [DUR_W-1:0] duration,
  input  logic             stop,
  input  logic             mute,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             spk
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_TICKS + 1);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state, state_d;
  logic [DIV_W-1:0] hp_q, div_cnt;
  logic [DUR_W-1:0] dur_q, dur_cnt;
  logic [TW-1:0] tick_cnt;
  logic [GW-1:0] gap_cnt;
  logic tone, done_q;
  logic accept, tick, div_wrap, play_end, gap_end;
  assign accept   = state == IDLE && start && !stop;
  assign tick     = tick_cnt == TW'(TICK_DIV - 1);
  assign div_wrap = hp_q != '0 && div_cnt == hp_q - DIV_W'(1);
  assign play_end = state == PLAY && tick && dur_cnt == dur_q - DUR_W'(1);
  assign gap_end  = state == GAP && tick && gap_cnt == GW'(GAP_TICKS - 1);
  always_comb begin
    state_d = accept ? (duration == '0 ? GAP : PLAY) :
              (state != IDLE && stop) ? IDLE :
              play_end ? GAP :
              gap_end ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_q     <= '0;
      dur_q    <= '0;
      div_cnt  <= '0;
      dur_cnt  <= '0;
      tick_cnt <= '0;
      gap_cnt  <= '0;
      tone     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= gap_end && !stop;
      if (accept) begin
        hp_q     <= half_period;
        dur_q    <= duration;
        div_cnt  <= '0;
        dur_cnt  <= '0;
        tick_cnt <= '0;
        gap_cnt  <= '0;
        tone     <= 1'b0;
      end else if (state == IDLE || stop) begin
        div_cnt  <= '0;
        dur_cnt  <= '0;
        tick_cnt <= '0;
        gap_cnt  <= '0;
        tone     <= 1'b0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (state == PLAY) begin
          div_cnt <= div_wrap ? '0 : (hp_q == '0 ? '0 : div_cnt + DIV_W'(1));
          tone    <= !play_end && (tone ^ div_wrap);
          dur_cnt <= play_end ? '0 : dur_cnt + DUR_W'(tick);
        end else begin
          tone    <= 1'b0;
          gap_cnt <= gap_end ? '0 : gap_cnt + GW'(tick);
        end
      end
    end
  end
  assign ready = state == IDLE;
  assign busy  = !ready;
  assign done  = done_q;
  // mute gates only the pin, so the divider phase survives a muted stretch
  assign spk   = tone && !mute;
endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed checks of tone_gen with TICK_DIV=4, GAP_TICKS=2.
module tb_tone_gen;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, mute = 1'b0;
  logic [7:0] half_period = '0, duration = '0;
  logic ready, busy, done, spk;
  int total = 0, passed = 0;

  tone_gen #(.DIV_W(8), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .half_period(half_period),
    .duration(duration), .stop(stop), .mute(mute), .ready(ready),
    .busy(busy), .done(done), .spk(spk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: ready/busy/done/spk got %b want %b", tag, obs, exp);
  endtask

  // expected outputs k cycles after the accepting edge of a note
  function automatic logic [3:0] expv(int k, int hp, int dur, int last, bit muted, bit stopped);
    logic r, d, s;
    r = stopped || k >= last;
    d = !stopped && k == last;
    s = !stopped && !muted && hp != 0 && k < dur * 4 && ((k / hp) % 2 == 1);
    return {r, !r, d, s};
  endfunction

  task automatic note(input string tag, input int hp, input int dur, input int ncyc,
                      input int mlo, input int mhi, input int stop_at,
                      input bit hold, input bit pulse);
    int last;
    last = (dur + 2) * 4;
    half_period = hp[7:0];
    duration = dur[7:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    if (!hold) begin
      half_period = 8'hAA;
      duration = 8'h55;
    end
    for (int k = 0; k <= ncyc; k++) begin
      int ke;
      bit st;
      mute = k >= mlo && k <= mhi;
      stop = k == stop_at - 1;
      start = hold || (pulse && k == 3);
      #1;
      ke = (hold && k > last) ? k - last - 1 : k;
      st = stop_at >= 0 && k >= stop_at;
      chk($sformatf("%s k=%0d", tag, k), {ready, busy, done, spk}, expv(ke, hp, dur, last, mute, st));
      @(posedge clk); #1;
    end
    start = 1'b0;
    stop = 1'b0;
    mute = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset", {ready, busy, done, spk}, 4'b1000);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle", {ready, busy, done, spk}, 4'b1000);
    note("basic", 3, 3, 21, -1, -2, -2, 1'b0, 1'b0);
    note("rest", 0, 2, 17, -1, -2, -2, 1'b0, 1'b0);
    note("dur0", 3, 0, 9, -1, -2, -2, 1'b0, 1'b0);
    note("stop", 3, 3, 21, -1, -2, 5, 1'b0, 1'b0);
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    chk("start+stop", {ready, busy, done, spk}, 4'b1000);
    @(posedge clk); #1;
    chk("start+stop after", {ready, busy, done, spk}, 4'b1000);
    note("ignored start", 3, 3, 21, -1, -2, -2, 1'b0, 1'b1);
    note("back2back", 3, 3, 27, -1, -2, -2, 1'b1, 1'b0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("b2b stopped", {ready, busy, done, spk}, 4'b1000);
    note("mute", 3, 3, 21, 2, 7, -2, 1'b0, 1'b0);
    half_period = 8'd3;
    duration = 8'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset", {ready, busy, done, spk}, 4'b0101);
    #2 reset = 1'b1;
    #1 chk("async reset", {ready, busy, done, spk}, 4'b1000);
    #1 reset = 1'b0;
    note("post-reset", 2, 1, 13, -1, -2, -2, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
